// File: rtl/wb_pkg.sv
// Shared types and constants for the multi-source writeback stage.
package wb_pkg;

    localparam int WB_XLEN    = 64;
    localparam int WB_REGBITS = 5;
    localparam int WB_PCW     = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ECALL_WAIT = 2'd1,
        ECALL_WB   = 2'd2
    } wb_state_e;

    // Plain-vector views of the state encoding for the FSM register
    localparam logic [1:0] ST_IDLE       = IDLE;
    localparam logic [1:0] ST_ECALL_WAIT = ECALL_WAIT;
    localparam logic [1:0] ST_ECALL_WB   = ECALL_WB;

    localparam logic [4:0] A0_IDX   = 5'd10;
    localparam logic [4:0] ZERO_IDX = 5'd0;

    typedef struct packed {
        logic [WB_REGBITS-1:0] rd;
        logic [WB_XLEN-1:0]    data;
        logic [WB_PCW-1:0]     pc;
        logic                  is_ecall;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module wb_rr_arb #(
    parameter int NUM_SRC = 2,
    parameter int IDXW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDXW-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [IDXW-1:0] ptr_reg;
    logic [IDXW-1:0] cand [NUM_SRC];

    // cand[gi] is the channel index gi positions after the pointer, wrapped
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
            assign cand[gi] = ((int'(ptr_reg) + gi) >= NUM_SRC)
                            ? IDXW'(int'(ptr_reg) + gi - NUM_SRC)
                            : IDXW'(int'(ptr_reg) + gi);
        end
    endgenerate

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[k];
            end
        end
    end

    assign grant = grant_valid ? (NUM_SRC'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= '0;
        end else if (advance && grant_valid) begin
            ptr_reg <= (grant_idx == IDXW'(NUM_SRC - 1)) ? '0 : grant_idx + IDXW'(1);
        end
    end

endmodule

// File: rtl/wb_multi.sv
// Multi-source writeback stage with round-robin retire and ECALL handshake.
// Define WB_BYPASS_EN to expose the combinational fwd_* forwarding outputs.
module wb_multi
    import wb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int XLEN    = 64,
    parameter int REGBITS = 5,
    parameter int PCW     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC*REGBITS-1:0] src_rd,
    input  logic [NUM_SRC*XLEN-1:0]    src_data,
    input  logic [NUM_SRC*PCW-1:0]     src_pc,
    input  logic [NUM_SRC-1:0]         src_is_ecall,
    input  logic                       flush_in,
    output logic                       ecall_req,
    input  logic                       ecall_ack,
    input  logic [XLEN-1:0]            ecall_ret,
    output logic                       rf_we,
    output logic [REGBITS-1:0]         rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic                       flush_out,
    output logic [PCW-1:0]             redirect_pc
`ifdef WB_BYPASS_EN
    ,
    output logic                       fwd_valid,
    output logic [REGBITS-1:0]         fwd_rd,
    output logic [XLEN-1:0]            fwd_data
`endif
);

    localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [1:0]         state_reg;
    logic [PCW-1:0]     pc_reg;
    logic               rf_we_reg;
    logic [REGBITS-1:0] rf_waddr_reg;
    logic [XLEN-1:0]    rf_wdata_reg;
    logic               flush_out_reg;
    logic [PCW-1:0]     redirect_pc_reg;

    logic [REGBITS-1:0] rd_arr   [NUM_SRC];
    logic [XLEN-1:0]    data_arr [NUM_SRC];
    logic [PCW-1:0]     pc_arr   [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign rd_arr[gi]   = src_rd[gi*REGBITS +: REGBITS];
            assign data_arr[gi] = src_data[gi*XLEN +: XLEN];
            assign pc_arr[gi]   = src_pc[gi*PCW +: PCW];
        end
    endgenerate

    logic [NUM_SRC-1:0] arb_req;
    logic [NUM_SRC-1:0] grant;
    logic [IDXW-1:0]    grant_idx;
    logic               transfer;

    // Producers are only offered to the arbiter while the stage is idle
    assign arb_req = (state_reg == ST_IDLE) ? src_valid : '0;

    wb_rr_arb #(
        .NUM_SRC(NUM_SRC),
        .IDXW   (IDXW)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (arb_req),
        .advance    (transfer),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(transfer)
    );

    logic [REGBITS-1:0] sel_rd;
    logic [XLEN-1:0]    sel_data;
    logic [PCW-1:0]     sel_pc;
    logic               sel_ecall;
    logic               accept_wr;
    logic               accept_ec;

    assign sel_rd    = rd_arr[grant_idx];
    assign sel_data  = data_arr[grant_idx];
    assign sel_pc    = pc_arr[grant_idx];
    assign sel_ecall = src_is_ecall[grant_idx];
    assign accept_wr = transfer && !flush_in && !sel_ecall;
    assign accept_ec = transfer && !flush_in && sel_ecall;

    assign src_ready = grant;
    assign ecall_req = (state_reg == ST_ECALL_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= '0;
            rf_we_reg       <= 1'b0;
            rf_waddr_reg    <= '0;
            rf_wdata_reg    <= '0;
            flush_out_reg   <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            rf_we_reg     <= 1'b0;
            flush_out_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept_wr) begin
                        rf_we_reg    <= (sel_rd != REGBITS'(ZERO_IDX));
                        rf_waddr_reg <= sel_rd;
                        rf_wdata_reg <= sel_data;
                    end else if (accept_ec) begin
                        pc_reg    <= sel_pc;
                        state_reg <= ST_ECALL_WAIT;
                    end
                end
                ST_ECALL_WAIT: begin
                    // The a0 write and flush are registered here so they are visible during ECALL_WB
                    if (ecall_ack) begin
                        rf_we_reg       <= 1'b1;
                        rf_waddr_reg    <= REGBITS'(A0_IDX);
                        rf_wdata_reg    <= ecall_ret;
                        flush_out_reg   <= 1'b1;
                        redirect_pc_reg <= pc_reg + PCW'(4);
                        state_reg       <= ST_ECALL_WB;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rf_we       = rf_we_reg;
    assign rf_waddr    = rf_waddr_reg;
    assign rf_wdata    = rf_wdata_reg;
    assign flush_out   = flush_out_reg;
    assign redirect_pc = redirect_pc_reg;

`ifdef WB_BYPASS_EN
    assign fwd_valid = accept_wr && (sel_rd != REGBITS'(ZERO_IDX));
    assign fwd_rd    = sel_rd;
    assign fwd_data  = sel_data;
`endif

endmodule

// File: doc/wb_multi.md
Name: wb_multi

Overview:
- Parametrised successor writeback stage.
- Accepts results from NUM_SRC producer channels (ALU, load, future mul/div) over valid/ready handshakes.
- Round-robin arbitration; retires one result per cycle into the register-file write port with one-cycle registered latency.
- Runs ECALLs as a multi-cycle handshake with an external ecall handler, then writes a0 and issues a one-cycle pipeline flush with redirect PC.

Parameters:
- NUM_SRC, 2, number of producer channels (1..8).
- XLEN, 64, data width.
- REGBITS, 5, register index width.
- PCW, 32, program-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src_valid  in  NUM_SRC  per-channel result valid.
- src_ready  out  NUM_SRC  per-channel accept (combinational).
- src_rd  in  NUM_SRC x REGBITS  destination register per channel.
- src_data  in  NUM_SRC x XLEN  result data per channel.
- src_pc  in  NUM_SRC x PCW  PC of the producing instruction.
- src_is_ecall  in  NUM_SRC  result is an ECALL.
- flush_in  in  1  upstream squash: accept and discard this cycle.
- ecall_req  out  1  level request to the ecall handler.
- ecall_ack  in  1  handler done; ecall_ret is valid.
- ecall_ret  in  XLEN  handler return value.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REGBITS  write address.
- rf_wdata  out  XLEN  write data.
- flush_out  out  1  one-cycle flush pulse.
- redirect_pc  out  PCW  fetch redirect target, valid with flush_out.

Behaviour:
- Reset (rst low, asynchronous):
  - rf_we, rf_waddr, rf_wdata, flush_out, redirect_pc, ecall_req all 0.
  - FSM goes to IDLE; round-robin pointer goes to 0.
  - A reset during ECALL_WAIT drops ecall_req immediately and produces no write.
- FSM states: IDLE, ECALL_WAIT, ECALL_WB.
- IDLE:
  - The arbiter grants the first valid channel at or after the pointer, wrapping modulo NUM_SRC.
  - src_ready is high only for the granted channel; the transfer is valid&ready.
  - The pointer moves to grant+1 (mod NUM_SRC) on each transfer; otherwise it holds.
  - A granted non-ECALL result is registered next cycle: rf_we=1, rf_waddr=src_rd, rf_wdata=src_data.
  - src_rd==0 is written as rf_we=0.
  - With no transfer, rf_we=0 next cycle.
- flush_in high in IDLE:
  - The granted channel is still accepted (ready high) but produces no write and no ECALL entry.
  - The pointer still advances.
- ECALL grant (no flush_in):
  - Capture pc = src_pc and go to ECALL_WAIT; rf_we=0 next cycle.
  - In ECALL_WAIT: all src_ready low; ecall_req=1 until the cycle ecall_ack is sampled high.
  - On ecall_ack: capture ecall_ret, drop ecall_req, go to ECALL_WB.
  - An ecall_ack arriving in the same cycle ecall_req first rises is honoured.
  - In ECALL_WB, for one cycle: rf_we=1, rf_waddr=10 (a0), rf_wdata=captured return, flush_out=1, redirect_pc=captured pc+4 (wraps mod 2^PCW). Then return to IDLE.
  - src_ready stays low through ECALL_WB.
- flush_out is high for exactly one cycle per ECALL; redirect_pc holds its value after the pulse.
- ecall_ack outside ECALL_WAIT is ignored.
- NUM_SRC=1 is legal: the pointer is constant 0.

Optional Feature:
- WB_BYPASS_EN defined:
  - Adds outputs fwd_valid (1), fwd_rd (REGBITS) and fwd_data (XLEN).
  - These are combinationally driven from the IDLE-state granted channel in the transfer cycle: valid when transferring, not ECALL, no flush_in, rd!=0.
  - Lets decode forward one cycle earlier.
- Undefined: the ports are absent and the timing is unchanged.

Decomposition:
- Package wb_pkg:
  - wb_state_e enum (IDLE, ECALL_WAIT, ECALL_WB).
  - Constants A0_IDX=5'd10, ZERO_IDX=5'd0.
  - Struct wb_req_t {rd, data, pc, is_ecall}, parametrised via localparams matching the defaults.
- Sub-module wb_rr_arb:
  - Parametrised NUM_SRC round-robin arbiter: req vector, advance strobe, one-hot grant and index, owns the pointer.

Test Plan:
- Single write: ch0 valid, rd=5, data=0xDEAD → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEAD.
- Round-robin: ch0 and ch1 both valid for 4 cycles (NUM_SRC=2) → grants alternate 0,1,0,1; each src_ready is high exactly twice.
- x0 suppression: rd=0, data=0x1 → rf_we=0, and the channel is still accepted.
- ECALL: ch1 is_ecall, pc=0x1000; ack returned 3 cycles later with ecall_ret=0x2A →
  - ecall_req high 3 cycles;
  - then one cycle with rf_we=1, rf_waddr=10, rf_wdata=0x2A, flush_out=1, redirect_pc=0x1004;
  - src_ready is 0 for the whole sequence.
- Flush squash: ch0 valid rd=3 with flush_in=1 → src_ready[0]=1, no write next cycle, pointer advances.
- Async reset in ECALL_WAIT: rst low between edges → ecall_req=0 immediately; after release the FSM is in IDLE, no a0 write, flush_out=0.
